// File: rtl/uart_ram_loader_pkg.sv
// Shared constants for the UART-to-RAM command loader.
// Contents:
//   - command opcodes (SET_ADDR / WRITE / READ)
//   - reply codes (ACK / NAK)
//   - FSM state encodings, S_CMD through S_REPLY
//   - addr_bytes(): number of little-endian bytes carried by SET_ADDR
package uart_ram_loader_pkg;

    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_READ     = 8'h03;

    localparam logic [7:0] ACK_BYTE    = 8'h06;
    localparam logic [7:0] NAK_BYTE    = 8'h15;

    localparam int STATE_W = 4;

    localparam logic [3:0] S_CMD      = 4'd0;
    localparam logic [3:0] S_ADDR     = 4'd1;
    localparam logic [3:0] S_LEN_LO   = 4'd2;
    localparam logic [3:0] S_LEN_HI   = 4'd3;
    localparam logic [3:0] S_WR_DATA  = 4'd4;
    localparam logic [3:0] S_WR_RAM   = 4'd5;
    localparam logic [3:0] S_WR_ECHO  = 4'd6;
    localparam logic [3:0] S_RD_ISSUE = 4'd7;
    localparam logic [3:0] S_RD_WAIT  = 4'd8;
    localparam logic [3:0] S_RD_TX    = 4'd9;
    localparam logic [3:0] S_REPLY    = 4'd10;

    function automatic int addr_bytes(input int aw);
        return (aw + 7) / 8;
    endfunction

endpackage

// File: rtl/rx_byte_latch.sv
// Single-byte receive holding register.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   rx_data_i      received byte, valid while rx_done_i is high
//   rx_done_i      one-cycle pulse per received byte
//   consume_i      consumer takes the held byte this cycle
//   data_o         held byte
//   full_o         a byte is held
//   overrun_o      sticky: a byte arrived while full and not being consumed
// Handshake: full_o acts as valid and consume_i as ready; the byte moves
// to the consumer on a clock where both are high.
module rx_byte_latch
    import uart_ram_loader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_done_i,
    input  logic       consume_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       overrun_o
);

    logic [7:0] data_q;
    logic       full_q;
    logic       overrun_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q    <= 8'h00;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (rx_done_i) begin
                // A consume in the same cycle frees the slot for the new byte.
                if (!full_q || consume_i) begin
                    data_q <= rx_data_i;
                    full_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (consume_i) begin
                full_q <= 1'b0;
            end
        end
    end

    assign data_o    = data_q;
    assign full_o    = full_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_ram_loader.sv
// Command-driven bridge between a byte UART and one port of a dual-port RAM.
// Commands: 0x01 SET_ADDR <addr LE>, 0x02 WRITE <len LE16> <data...>,
//           0x03 READ <len LE16>. Each command ends with ACK (0x06);
//           unknown opcodes get NAK (0x15).
// Ports:
//   clk, rst                 shared clock, synchronous active-high reset
//   rx_data, rx_done         received byte stream
//   tx_data, tx_wr, tx_done  transmit request / completion
//   ram_addr, ram_di, ram_we RAM write/read port (ram_do returns RD_LAT later)
//   busy                     FSM is not waiting for a command
//   overrun                  sticky lost-byte flag
//   dbg_state                current FSM state
// TX handshake: tx_wr is raised for one clock only while the transmitter is
// idle; it is then busy until tx_done, and tx_data holds during that time.
module uart_ram_loader
    import uart_ram_loader_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1,
    parameter int ECHO   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_di,
    output logic              ram_we,
    input  logic [7:0]        ram_do,
    output logic              busy,
    output logic              overrun,
    output logic [3:0]        dbg_state
);

    localparam int ABYTES = addr_bytes(ADDR_W);

    if (DATA_W != 8) begin : g_bad_data_w
        $error("uart_ram_loader: DATA_W must be 8");
    end
    if (ADDR_W < 1 || ADDR_W > 24 || RD_LAT < 1 || RD_LAT > 3 || LEN_W < 1 || LEN_W > 16) begin : g_bad_param
        $error("uart_ram_loader: parameter out of range");
    end

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic              is_read_q, is_read_d;
    logic [1:0]        addr_idx_q, addr_idx_d;
    logic [1:0]        wait_q, wait_d;
    logic [7:0]        rd_byte_q, rd_byte_d;
    logic [7:0]        reply_q, reply_d;
    logic              tx_idle_q, tx_idle_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_wr_q, tx_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_di_q, ram_di_d;
    logic              ram_we_q, ram_we_d;

    logic [7:0]          hold_data;
    logic                hold_full;
    logic                consume;
    logic [ABYTES*8-1:0] addr_tmp;

    rx_byte_latch u_rx_latch (
        .clk_i     (clk),
        .rst_i     (rst),
        .rx_data_i (rx_data),
        .rx_done_i (rx_done),
        .consume_i (consume),
        .data_o    (hold_data),
        .full_o    (hold_full),
        .overrun_o (overrun)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        len_lo_d   = len_lo_q;
        is_read_d  = is_read_q;
        addr_idx_d = addr_idx_q;
        wait_d     = wait_q;
        rd_byte_d  = rd_byte_q;
        reply_d    = reply_q;
        tx_data_d  = tx_data_q;
        tx_wr_d    = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;
        ram_we_d   = 1'b0;
        consume    = 1'b0;
        addr_tmp   = (ABYTES*8)'(ptr_q);

        case (state_q)
            S_CMD: if (hold_full) begin
                consume = 1'b1;
                case (hold_data)
                    OP_SET_ADDR: begin
                        addr_idx_d = 2'd0;
                        state_d    = S_ADDR;
                    end
                    OP_WRITE, OP_READ: begin
                        is_read_d = (hold_data == OP_READ);
                        state_d   = S_LEN_LO;
                    end
                    default: begin
                        reply_d = NAK_BYTE;
                        state_d = S_REPLY;
                    end
                endcase
            end
            S_ADDR: if (hold_full) begin
                consume = 1'b1;
                // Bytes arrive LSB first; bits above ADDR_W fall off in the cast.
                addr_tmp[{addr_idx_q, 3'b000} +: 8] = hold_data;
                ptr_d = ADDR_W'(addr_tmp);
                if (addr_idx_q == 2'(ABYTES - 1)) begin
                    reply_d = ACK_BYTE;
                    state_d = S_REPLY;
                end else begin
                    addr_idx_d = addr_idx_q + 2'd1;
                end
            end
            S_LEN_LO: if (hold_full) begin
                consume  = 1'b1;
                len_lo_d = hold_data;
                state_d  = S_LEN_HI;
            end
            S_LEN_HI: if (hold_full) begin
                consume = 1'b1;
                len_d   = LEN_W'({hold_data, len_lo_q});
                if (len_d == '0) begin
                    reply_d = ACK_BYTE;
                    state_d = S_REPLY;
                end else begin
                    state_d = is_read_q ? S_RD_ISSUE : S_WR_DATA;
                end
            end
            S_WR_DATA: if (hold_full) begin
                // Registered strobe: ram_we is high exactly while in S_WR_RAM.
                consume    = 1'b1;
                ram_addr_d = ptr_q;
                ram_di_d   = hold_data;
                ram_we_d   = 1'b1;
                state_d    = S_WR_RAM;
            end
            S_WR_RAM: begin
                ptr_d = ptr_q + 1'b1;
                len_d = len_q - 1'b1;
                if (ECHO != 0) begin
                    state_d = S_WR_ECHO;
                end else if (len_q == LEN_W'(1)) begin
                    reply_d = ACK_BYTE;
                    state_d = S_REPLY;
                end else begin
                    state_d = S_WR_DATA;
                end
            end
            S_WR_ECHO: if (tx_idle_q) begin
                // len was already decremented in S_WR_RAM.
                tx_wr_d   = 1'b1;
                tx_data_d = ram_di_q;
                if (len_q == '0) begin
                    reply_d = ACK_BYTE;
                    state_d = S_REPLY;
                end else begin
                    state_d = S_WR_DATA;
                end
            end
            S_RD_ISSUE: begin
                ram_addr_d = ptr_q;
                wait_d     = 2'd0;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // ram_addr became visible on entry; wait_q counts clocks since.
                if (wait_q == 2'(RD_LAT)) begin
                    rd_byte_d = ram_do;
                    state_d   = S_RD_TX;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_RD_TX: if (tx_idle_q) begin
                tx_wr_d   = 1'b1;
                tx_data_d = rd_byte_q;
                ptr_d     = ptr_q + 1'b1;
                len_d     = len_q - 1'b1;
                if (len_q == LEN_W'(1)) begin
                    reply_d = ACK_BYTE;
                    state_d = S_REPLY;
                end else begin
                    state_d = S_RD_ISSUE;
                end
            end
            S_REPLY: if (tx_idle_q) begin
                tx_wr_d   = 1'b1;
                tx_data_d = reply_q;
                state_d   = S_CMD;
            end
            default: state_d = S_CMD;
        endcase

        // Issuing a request claims the transmitter before tx_done can be seen.
        if (tx_wr_d) begin
            tx_idle_d = 1'b0;
        end else if (tx_done) begin
            tx_idle_d = 1'b1;
        end else begin
            tx_idle_d = tx_idle_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CMD;
            ptr_q      <= '0;
            len_q      <= '0;
            len_lo_q   <= 8'h00;
            is_read_q  <= 1'b0;
            addr_idx_q <= 2'd0;
            wait_q     <= 2'd0;
            rd_byte_q  <= 8'h00;
            reply_q    <= 8'h00;
            tx_idle_q  <= 1'b1;
            tx_data_q  <= 8'h00;
            tx_wr_q    <= 1'b0;
            ram_addr_q <= '0;
            ram_di_q   <= 8'h00;
            ram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            len_lo_q   <= len_lo_d;
            is_read_q  <= is_read_d;
            addr_idx_q <= addr_idx_d;
            wait_q     <= wait_d;
            rd_byte_q  <= rd_byte_d;
            reply_q    <= reply_d;
            tx_idle_q  <= tx_idle_d;
            tx_data_q  <= tx_data_d;
            tx_wr_q    <= tx_wr_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
            ram_we_q   <= ram_we_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_wr     = tx_wr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_di    = ram_di_q;
    assign ram_we    = ram_we_q;
    assign busy      = (state_q != S_CMD);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
module tb_uart_ram_loader;

    localparam int ADDR_W = 14;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_done = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              tx_done;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_di;
    logic              ram_we;
    logic [7:0]        ram_do;
    logic              busy;
    logic              overrun;
    logic [3:0]        dbg_state;

    logic tx_auto      = 1'b1;
    logic tx_done_auto = 1'b0;
    logic tx_done_man  = 1'b0;
    assign tx_done = tx_done_auto | tx_done_man;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int we_base;

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] rd_p1, rd_p2;

    uart_ram_loader #(
        .ADDR_W(ADDR_W), .DATA_W(8), .LEN_W(16), .RD_LAT(RD_LAT), .ECHO(1)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_do(ram_do),
        .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model, two-stage read pipeline ----------------
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_di;
        rd_p1 <= mem[ram_addr];
        rd_p2 <= rd_p1;
    end
    assign ram_do = rd_p2;

    // ---------------- transmitter model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (tx_wr && tx_auto) begin
                repeat (3) @(negedge clk);
                tx_done_auto = 1'b1;
                @(negedge clk);
                tx_done_auto = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (tx_wr) tx_q.push_back(tx_data);
        if (ram_we) we_cnt++;
    end

    // ---------------- global time limit ----------------
    initial begin
        #2000000;
        $display("FAIL time_limit simulation did not finish");
        $fatal(1, "time limit");
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_tx(input string tag);
        int n = 0;
        while (tx_q.size() < exp_q.size() && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_count"}, 32'(tx_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && tx_q.size() > 0)
            chk(tag, 32'(tx_q.pop_front()), 32'(exp_q.pop_front()));
        tx_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done_man = 1'b1;
        @(negedge clk);
        tx_done_man = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_wr",    32'(tx_wr), 32'd0);
        chk("rst_tx_data",  32'(tx_data), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_di",   32'(ram_di), 32'd0);
        chk("rst_ram_we",   32'(ram_we), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_overrun",  32'(overrun), 32'd0);
        chk("rst_state",    32'(dbg_state), 32'd0);

        // SET_ADDR 0x3800
        send(8'h01); send(8'h00); send(8'h38);
        wait_idle("setaddr");
        exp_q.push_back(8'h06);
        check_tx("setaddr_tx");

        // WRITE 3 bytes; first data byte timed to check the 2-clock path
        we_base = we_cnt;
        send(8'h02); send(8'h03); send(8'h00);
        @(negedge clk);
        rx_data = 8'hAA;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        chk("wr_we_early", 32'(ram_we), 32'd0);
        @(negedge clk);
        chk("wr_we_lat2", 32'(ram_we), 32'd1);
        chk("wr_addr_lat2", 32'(ram_addr), 32'h3800);
        chk("wr_di_lat2", 32'(ram_di), 32'hAA);
        @(negedge clk);
        chk("wr_we_one_clk", 32'(ram_we), 32'd0);
        repeat (12) @(negedge clk);
        send(8'hBB); send(8'hCC);
        wait_idle("write");
        chk("wr_mem0", 32'(mem[14'h3800]), 32'hAA);
        chk("wr_mem1", 32'(mem[14'h3801]), 32'hBB);
        chk("wr_mem2", 32'(mem[14'h3802]), 32'hCC);
        chk("wr_we_count", 32'(we_cnt - we_base), 32'd3);
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
        exp_q.push_back(8'hCC); exp_q.push_back(8'h06);
        check_tx("write_tx");

        // WRITE across the top of the address space, then READ it back
        send(8'h01); send(8'hFE); send(8'h3F);
        wait_idle("setaddr2");
        send(8'h02); send(8'h04); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_idle("write_wrap");
        chk("wrap_mem_3ffe", 32'(mem[14'h3FFE]), 32'h11);
        chk("wrap_mem_3fff", 32'(mem[14'h3FFF]), 32'h22);
        chk("wrap_mem_0000", 32'(mem[14'h0000]), 32'h33);
        chk("wrap_mem_0001", 32'(mem[14'h0001]), 32'h44);
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'h06);
        check_tx("write_wrap_tx");

        we_base = we_cnt;
        send(8'h01); send(8'hFE); send(8'h3F);
        send(8'h03); send(8'h04); send(8'h00);
        wait_idle("read");
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'h06);
        check_tx("read_tx");
        chk("read_no_we", 32'(we_cnt - we_base), 32'd0);

        // Bad opcode and zero-length WRITE
        send(8'h7F);
        wait_idle("badop");
        exp_q.push_back(8'h15);
        check_tx("badop_tx");
        we_base = we_cnt;
        send(8'h02); send(8'h00); send(8'h00);
        wait_idle("zerolen");
        exp_q.push_back(8'h06);
        check_tx("zerolen_tx");
        chk("zerolen_no_we", 32'(we_cnt - we_base), 32'd0);

        // Overrun while stalled on a pending transmit
        tx_auto = 1'b0;
        send(8'h7F);
        @(negedge clk); rx_data = 8'h7F; rx_done = 1'b1;
        @(negedge clk); rx_data = 8'h7F;
        @(negedge clk); rx_data = 8'h01;
        @(negedge clk); rx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_stall_state", 32'(dbg_state), 32'd10);
        pulse_tx_done();
        pulse_tx_done();
        chk("ovr_third_dropped", 32'(busy), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        pulse_tx_done();
        tx_auto = 1'b1;
        exp_q.push_back(8'h15); exp_q.push_back(8'h15); exp_q.push_back(8'h15);
        check_tx("ovr_tx");
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Reset in the middle of a WRITE
        we_base = we_cnt;
        send(8'h02); send(8'h03); send(8'h00);
        send(8'h11); send(8'h22);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_tx_wr",    32'(tx_wr), 32'd0);
        chk("mid_tx_data",  32'(tx_data), 32'd0);
        chk("mid_ram_we",   32'(ram_we), 32'd0);
        chk("mid_ram_addr", 32'(ram_addr), 32'd0);
        chk("mid_ram_di",   32'(ram_di), 32'd0);
        chk("mid_busy",     32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        check_tx("mid_no_reply");
        chk("mid_we_count", 32'(we_cnt - we_base), 32'd2);
        send(8'h7F);
        wait_idle("mid_badop");
        exp_q.push_back(8'h15);
        check_tx("mid_badop_tx");

        // Pointer was cleared by reset: a 1-byte WRITE lands at 0x0000
        send(8'h02); send(8'h01); send(8'h00); send(8'h5A);
        wait_idle("ptr_reset");
        chk("ptr_reset_mem", 32'(mem[14'h0000]), 32'h5A);
        exp_q.push_back(8'h5A); exp_q.push_back(8'h06);
        check_tx("ptr_reset_tx");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
